// File: rtl/apb_loader_pkg.sv
// Shared FSM state encoding and CatRecognizer register map for the APB image loader.
package apb_loader_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR_SETUP,
    CLR_ACCESS,
    FILL,
    WR_SETUP,
    WR_ACCESS,
    ST_SETUP,
    ST_ACCESS,
    WAIT,
    REPORT
  } state_t;

  localparam int START_ADDR     = 0;
  localparam int FIRST_PIX_ADDR = 1;

  localparam int START_OFF = 0;
  localparam int START_ON  = 1;

endpackage

// File: rtl/pixel_packer.sv
// Packs consecutive pixels into one APB word, first pixel in the most significant byte.
module pixel_packer #(
  parameter int PixelWidth = 8,
  parameter int Amba_Word  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  take,
  input  logic [PixelWidth-1:0] pix,
  output logic                  word_full,
  output logic [Amba_Word-1:0]  word
);

  logic [1:0] byte_cnt;

  // Shifting left means the oldest pixel ends up in the top byte after three takes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= 2'd0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      word     <= '0;
    end else if (take) begin
      word     <= {word[Amba_Word-PixelWidth-1:0], pix};
      byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
    end
  end

  assign word_full = take && (byte_cnt == 2'd2);

endmodule

// File: rtl/apb_image_loader.sv
// APB master that streams one image into CatRecognizer, triggers it and samples the verdict.
//   state      | meaning
//   IDLE       | waiting for go
//   CLR_*      | APB write START_OFF to the start register
//   FILL       | accepting pixels until a word is complete
//   WR_*       | APB write of the packed word to address word_cnt
//   ST_*       | APB write START_ON to the start register
//   WAIT       | counting down the recognizer's processing time
//   REPORT     | result_valid pulse, back to IDLE
module apb_image_loader
  import apb_loader_pkg::*;
#(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 12,
  parameter int PixelWidth      = 8,
  parameter int NumPixels       = 12288,
  parameter int ResultWait      = 4150
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic [PixelWidth-1:0]    pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [Amba_Addr_Depth:0] PADDR,
  output logic [Amba_Word-1:0]     PWDATA,
  input  logic                     cat_in,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     result
);

  localparam int Words = NumPixels / 3;
  localparam int AddrW = Amba_Addr_Depth + 1;
  localparam int WaitW = $clog2(ResultWait + 1);

  state_t             state, state_nxt;
  logic [AddrW-1:0]   word_cnt;
  logic [WaitW-1:0]   wait_cnt;
  logic               take, word_full, pack_clear;
  logic [Amba_Word-1:0] packed_word;
  logic               last_word, wait_done;

  assign pix_ready    = (state == FILL);
  assign pack_clear   = (state == CLR_ACCESS);
  assign take         = pix_valid && pix_ready;
  assign last_word    = (word_cnt == AddrW'(Words));
  assign wait_done    = (wait_cnt == WaitW'(ResultWait - 1));
  assign busy         = (state != IDLE) && (state != REPORT);
  assign result_valid = (state == REPORT);

  pixel_packer #(
    .PixelWidth (PixelWidth),
    .Amba_Word  (Amba_Word)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .take      (take),
    .pix       (pix_data),
    .word_full (word_full),
    .word      (packed_word)
  );

  // The verdict is captured on entry to REPORT so result is already valid during the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      wait_cnt <= '0;
      result   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        CLR_ACCESS: word_cnt <= AddrW'(FIRST_PIX_ADDR);
        WR_ACCESS:  if (!last_word) word_cnt <= word_cnt + AddrW'(1);
        ST_ACCESS:  wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + WaitW'(1);
          if (wait_done) result <= cat_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    PWRITE    = 1'b0;
    PADDR     = '0;
    PWDATA    = '0;
    case (state)
      IDLE: if (go) state_nxt = CLR_SETUP;
      CLR_SETUP: begin
        PSEL      = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = AddrW'(START_ADDR);
        PWDATA    = Amba_Word'(START_OFF);
        state_nxt = CLR_ACCESS;
      end
      CLR_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = AddrW'(START_ADDR);
        PWDATA    = Amba_Word'(START_OFF);
        state_nxt = FILL;
      end
      FILL: if (word_full) state_nxt = WR_SETUP;
      WR_SETUP: begin
        PSEL      = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = word_cnt;
        PWDATA    = packed_word;
        state_nxt = WR_ACCESS;
      end
      WR_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = word_cnt;
        PWDATA    = packed_word;
        state_nxt = last_word ? ST_SETUP : FILL;
      end
      ST_SETUP: begin
        PSEL      = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = AddrW'(START_ADDR);
        PWDATA    = Amba_Word'(START_ON);
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        PWRITE    = 1'b1;
        PADDR     = AddrW'(START_ADDR);
        PWDATA    = Amba_Word'(START_ON);
        state_nxt = WAIT;
      end
      WAIT:    if (wait_done) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
